regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Write-port controller/scheduler in front of the 8x16 register file.
- Sequences a post-reset register clear, because FPGA reset must zero all registers.
- Shares the single write port between the ALU writeback path and the load-return path.
- Drives the register file's clk_en, write, movi, immediate and flag inputs from registered outputs.

Parameters:
NUM_REG, 8, number of registers cleared by the init sequence
ADDR_W, 3, register index width
DATA_W, 16, register data width

Ports:
clk_pi  in  1  clock
reset_n_pi  in  1  asynchronous active-low reset
init_start_pi  in  1  pulse: start clear sequence
alu_valid_pi  in  1  ALU writeback request
alu_ready_po  out  1  ALU holding buffer empty
alu_dest_pi  in  ADDR_W  ALU destination register
alu_data_pi  in  DATA_W  ALU result
alu_movi_lower_pi  in  1  movi-low command
alu_movi_higher_pi  in  1  movi-high command
alu_imm_pi  in  8  movi immediate
alu_carry_pi  in  1  new carry
alu_borrow_pi  in  1  new borrow
ld_valid_pi  in  1  load-return request
ld_ready_po  out  1  load holding buffer empty
ld_dest_pi  in  ADDR_W  load destination register
ld_data_pi  in  DATA_W  load data
cur_carry_pi  in  1  current carry flag from register file
cur_borrow_pi  in  1  current borrow flag from register file
rf_clk_en_po  out  1  register file clock enable
rf_wr_po  out  1  register file write enable
rf_dest_po  out  ADDR_W  register file destination index
rf_data_po  out  DATA_W  register file write data
rf_movi_lower_po  out  1  movi-low to register file
rf_movi_higher_po  out  1  movi-high to register file
rf_imm_po  out  8  immediate to register file
rf_carry_po  out  1  carry to register file
rf_borrow_po  out  1  borrow to register file
init_done_po  out  1  clear sequence complete, RUN state
busy_po  out  1  state is INIT or DRAIN

Behaviour:
- Reset (async, reset_n_pi=0) clears everything:
  - state=IDLE; every output 0.
  - Both holding buffers empty; ready outputs 0.
  - init counter=0; age bit cleared.
- FSM states: IDLE, INIT, RUN, DRAIN.
- IDLE: init_start_pi=1 -> INIT.
- INIT:
  - One write per cycle for cnt=0..NUM_REG-1: rf_clk_en=1, rf_wr=1, rf_dest=cnt, rf_data=0, movi=0, carry=borrow=0.
  - After the cnt=NUM_REG-1 write -> RUN; init_done_po=1 from the next cycle.
  - init_start_pi is ignored while in INIT.
- RUN:
  - ready_po for a source = its holding buffer is empty (registered).
  - valid&ready at edge N captures the request into that buffer.
  - The arbiter loads the output register at edge N+1; the register file commits at edge N+2.
  - The buffer frees at edge N+1, so ready_po returns to 1 in the following cycle.
  - At most one issue per cycle. Outputs are registered; there is no combinational path from input to output.
- Arbitration order:
  - The older entry issues first; age is set by capture edge.
  - Same-edge tie: load wins, ALU issues in the next cycle.
  - Consequence: writes to the same destination commit in capture order; no starvation.
- ALU issue: rf_data, dest, movi bits, imm, alu_carry and alu_borrow are forwarded.
  - If both movi bits are set, movi_higher wins; the controller clears movi_lower.
- Load issue: movi=0, imm=0; carry/borrow = cur_carry_pi/cur_borrow_pi, so the flags are preserved.
- No issue in a cycle: rf_clk_en=0, rf_wr=0; other rf outputs hold their last values.
- init_start_pi in RUN -> DRAIN:
  - Both ready outputs drop next cycle.
  - Held entries are issued in age order.
  - When both buffers are empty -> INIT; init_done_po=0 on entering DRAIN.
- Valid inputs while ready=0 are ignored (not captured).
- Reset mid-INIT or mid-DRAIN: the sequence is abandoned; pending buffer contents are discarded.

Optional Feature:
- Macro name: REGFILE_ARB_PERF_EN.
- When defined, adds two outputs:
  - wr_count_po (16): increments on every RUN/DRAIN issue; saturates at 16'hFFFF.
  - conflict_count_po (16): increments each cycle both buffers are full; saturates at 16'hFFFF.
  - Both counters clear on reset and on INIT entry.
- When undefined, these ports and the logic behind them do not exist.

Test Plan:
- Reset, then init_start pulse -> 8 consecutive writes dest 0..7, data 0, flags 0; init_done_po=1 on cycle 10 after the pulse.
- RUN: ALU dest=3, data=16'hBEEF, carry=1 -> exactly 2 edges later rf_wr=1, rf_dest=3, rf_data=BEEF, rf_carry=1, and alu_ready_po has returned to 1.
- Same-edge ALU (dest 2, 0x1111) and load (dest 5, 0x2222) -> load issues first, ALU next cycle; load carries cur_carry_pi/cur_borrow_pi unchanged.
- Load captured at N and ALU captured at N+1, both dest 4 -> load issues first; final value is the ALU data.
- ALU movi_lower=1, movi_higher=1, imm=8'hA5 -> rf_movi_higher=1, rf_movi_lower=0, rf_imm=A5.
- Both buffers full, then init_start -> DRAIN issues both entries, then 8 clear writes; reset_n_pi low mid-INIT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Write-port scheduler for the 8x16 register file: post-reset clear sequence plus ALU/load arbitration.
// Optional performance counters are enabled with the REGFILE_ARB_PERF_EN macro.
module regfile_wr_arbiter #(
    parameter int unsigned NUM_REG = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk_pi,
    input  logic              reset_n_pi,
    input  logic              init_start_pi,
    input  logic              alu_valid_pi,
    output logic              alu_ready_po,
    input  logic [ADDR_W-1:0] alu_dest_pi,
    input  logic [DATA_W-1:0] alu_data_pi,
    input  logic              alu_movi_lower_pi,
    input  logic              alu_movi_higher_pi,
    input  logic [7:0]        alu_imm_pi,
    input  logic              alu_carry_pi,
    input  logic              alu_borrow_pi,
    input  logic              ld_valid_pi,
    output logic              ld_ready_po,
    input  logic [ADDR_W-1:0] ld_dest_pi,
    input  logic [DATA_W-1:0] ld_data_pi,
    input  logic              cur_carry_pi,
    input  logic              cur_borrow_pi,
    output logic              rf_clk_en_po,
    output logic              rf_wr_po,
    output logic [ADDR_W-1:0] rf_dest_po,
    output logic [DATA_W-1:0] rf_data_po,
    output logic              rf_movi_lower_po,
    output logic              rf_movi_higher_po,
    output logic [7:0]        rf_imm_po,
    output logic              rf_carry_po,
    output logic              rf_borrow_po,
    output logic              init_done_po,
`ifdef REGFILE_ARB_PERF_EN
    output logic              busy_po,
    output logic [15:0]       wr_count_po,
    output logic [15:0]       conflict_count_po
`else
    output logic              busy_po
`endif
);

    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NUM_REG - 1);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun,
        StDrain
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [ADDR_W-1:0] cnt_q;

    // ALU holding buffer
    logic              alu_full_q;
    logic              alu_full_d;
    logic [ADDR_W-1:0] alu_dest_q;
    logic [DATA_W-1:0] alu_data_q;
    logic              alu_movi_lower_q;
    logic              alu_movi_higher_q;
    logic [7:0]        alu_imm_q;
    logic              alu_carry_q;
    logic              alu_borrow_q;

    // Load holding buffer
    logic              ld_full_q;
    logic              ld_full_d;
    logic [ADDR_W-1:0] ld_dest_q;
    logic [DATA_W-1:0] ld_data_q;

    // Set when the ALU entry was captured before the load entry
    logic              alu_older_q;
    logic              alu_older_d;

    logic              alu_cap;
    logic              ld_cap;
    logic              can_issue;
    logic              issue_alu;
    logic              issue_ld;

    always_comb begin
        alu_cap   = alu_valid_pi & alu_ready_po;
        ld_cap    = ld_valid_pi & ld_ready_po;
        can_issue = (state_q == StRun) || (state_q == StDrain);

        issue_ld  = can_issue & ld_full_q & (~alu_full_q | ~alu_older_q);
        issue_alu = can_issue & alu_full_q & ~issue_ld;

        alu_full_d = (alu_full_q & ~issue_alu) | alu_cap;
        ld_full_d  = (ld_full_q & ~issue_ld) | ld_cap;

        // The most recent capture is the younger entry; a same-edge tie favours the load.
        alu_older_d = alu_older_q;
        if (alu_cap) begin
            alu_older_d = 1'b0;
        end else if (ld_cap) begin
            alu_older_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (init_start_pi) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                if (cnt_q == LastReg) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (init_start_pi) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!alu_full_d && !ld_full_d) begin
                    state_d = StInit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            alu_full_q        <= 1'b0;
            ld_full_q         <= 1'b0;
            alu_older_q       <= 1'b0;
            alu_ready_po      <= 1'b0;
            ld_ready_po       <= 1'b0;
            alu_dest_q        <= '0;
            alu_data_q        <= '0;
            alu_movi_lower_q  <= 1'b0;
            alu_movi_higher_q <= 1'b0;
            alu_imm_q         <= '0;
            alu_carry_q       <= 1'b0;
            alu_borrow_q      <= 1'b0;
            ld_dest_q         <= '0;
            ld_data_q         <= '0;
        end else begin
            alu_full_q   <= alu_full_d;
            ld_full_q    <= ld_full_d;
            alu_older_q  <= alu_older_d;
            alu_ready_po <= (state_d == StRun) && !alu_full_d;
            ld_ready_po  <= (state_d == StRun) && !ld_full_d;
            if (alu_cap) begin
                alu_dest_q        <= alu_dest_pi;
                alu_data_q        <= alu_data_pi;
                alu_movi_lower_q  <= alu_movi_lower_pi;
                alu_movi_higher_q <= alu_movi_higher_pi;
                alu_imm_q         <= alu_imm_pi;
                alu_carry_q       <= alu_carry_pi;
                alu_borrow_q      <= alu_borrow_pi;
            end
            if (ld_cap) begin
                ld_dest_q <= ld_dest_pi;
                ld_data_q <= ld_data_pi;
            end
        end
    end

    // State register and all register-file outputs.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            init_done_po      <= 1'b0;
            busy_po           <= 1'b0;
            rf_clk_en_po      <= 1'b0;
            rf_wr_po          <= 1'b0;
            rf_dest_po        <= '0;
            rf_data_po        <= '0;
            rf_movi_lower_po  <= 1'b0;
            rf_movi_higher_po <= 1'b0;
            rf_imm_po         <= '0;
            rf_carry_po       <= 1'b0;
            rf_borrow_po      <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_po      <= (state_d == StInit) || (state_d == StDrain);
            init_done_po <= (state_q == StRun) && (state_d == StRun);
            cnt_q        <= (state_q == StInit) ? cnt_q + 1'b1 : '0;
            rf_clk_en_po <= 1'b0;
            rf_wr_po     <= 1'b0;

            if (state_q == StInit) begin
                rf_clk_en_po      <= 1'b1;
                rf_wr_po          <= 1'b1;
                rf_dest_po        <= cnt_q;
                rf_data_po        <= '0;
                rf_movi_lower_po  <= 1'b0;
                rf_movi_higher_po <= 1'b0;
                rf_imm_po         <= '0;
                rf_carry_po       <= 1'b0;
                rf_borrow_po      <= 1'b0;
            end else if (issue_ld) begin
                // Loads rewrite the current flags so they survive the write.
                rf_clk_en_po      <= 1'b1;
                rf_wr_po          <= 1'b1;
                rf_dest_po        <= ld_dest_q;
                rf_data_po        <= ld_data_q;
                rf_movi_lower_po  <= 1'b0;
                rf_movi_higher_po <= 1'b0;
                rf_imm_po         <= '0;
                rf_carry_po       <= cur_carry_pi;
                rf_borrow_po      <= cur_borrow_pi;
            end else if (issue_alu) begin
                rf_clk_en_po      <= 1'b1;
                rf_wr_po          <= 1'b1;
                rf_dest_po        <= alu_dest_q;
                rf_data_po        <= alu_data_q;
                rf_movi_lower_po  <= alu_movi_lower_q & ~alu_movi_higher_q;
                rf_movi_higher_po <= alu_movi_higher_q;
                rf_imm_po         <= alu_imm_q;
                rf_carry_po       <= alu_carry_q;
                rf_borrow_po      <= alu_borrow_q;
            end
        end
    end

`ifdef REGFILE_ARB_PERF_EN
    logic init_entry;
    assign init_entry = (state_d == StInit) && (state_q != StInit);

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            wr_count_po       <= '0;
            conflict_count_po <= '0;
        end else if (init_entry) begin
            wr_count_po       <= '0;
            conflict_count_po <= '0;
        end else begin
            if ((issue_alu || issue_ld) && (wr_count_po != 16'hFFFF)) begin
                wr_count_po <= wr_count_po + 16'd1;
            end
            if (alu_full_q && ld_full_q && (conflict_count_po != 16'hFFFF)) begin
                conflict_count_po <= conflict_count_po + 16'd1;
            end
        end
    end
`endif

endmodule
